// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit arbiter.
//   UART_BYTE_W  width of one transmitted byte
//   arb_state_t  arbiter FSM state encoding
//   clog2()      ceiling log2, used for index and counter widths
package uart_pkg;

    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_WRITE   = 2'b01,
        ST_RELEASE = 2'b11,
        ST_DRAIN   = 2'b10
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the arbiter.
//   req       level request per requester
//   req_data  byte of requester i at [8*i+7:8*i]
//   gnt       one-hot grant pulse
//   tx_data   byte presented to the transmitter
//   tx_wr     write strobe to the transmitter
//   tx_ce     chip enable to the transmitter (same timing as tx_wr)
//   tx_busy   transmitter busy
// Modports: master = arbiter view, slave = clients/transmitter view.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]             req;
    logic [UART_BYTE_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]             gnt;
    logic [UART_BYTE_W-1:0]       tx_data;
    logic                         tx_wr;
    logic                         tx_ce;
    logic                         tx_busy;

    modport master (
        input  req, req_data, tx_busy,
        output gnt, tx_data, tx_wr, tx_ce
    );

    modport slave (
        output req, req_data, tx_busy,
        input  gnt, tx_data, tx_wr, tx_ce
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req  request vector
//   ptr  index of the previous winner; search starts just after it
//   gnt  one-hot winner
//   idx  index of the winner
//   vld  at least one request set
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]        gnt,
    output logic [clog2(N_REQ)-1:0] idx,
    output logic                    vld
);
    localparam int IW = clog2(N_REQ);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        vld  = 1'b0;
        cand = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!vld && req[IW'(cand)]) begin
                vld             = 1'b1;
                idx             = IW'(cand);
                gnt[IW'(cand)]  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART byte transmitter between N_REQ requesters
// with round-robin arbitration. One byte is captured per grant, then tx_wr/tx_ce
// are held for WR_CYCLES clocks so the transmitter's divided clock sees them,
// and the arbiter waits for the frame (tx_busy high then low) before granting again.
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-low
//   bus          uart_tx_arbiter_if.master (req/req_data/gnt, tx_data/tx_wr/tx_ce/tx_busy)
//   owner        index of the last granted requester
//   active       high whenever the FSM is not idle
//   timeout_err  sticky timeout flag
// Option: define UART_ARB_TIMEOUT_EN to abort RELEASE/DRAIN after TO_CYCLES
// clocks and raise timeout_err; otherwise those states wait indefinitely.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int WR_CYCLES = 24,
    parameter int TO_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    rst,
    uart_tx_arbiter_if.master       bus,
    output logic [clog2(N_REQ)-1:0] owner,
    output logic                    active,
    output logic                    timeout_err
);
    localparam int IW    = clog2(N_REQ);
    localparam int CNT_W = clog2(((WR_CYCLES > TO_CYCLES) ? WR_CYCLES : TO_CYCLES) + 1);

    arb_state_t             state_q, state_d;
    logic [CNT_W-1:0]       wr_cnt_q, wr_cnt_d;
    logic [IW-1:0]          rr_q, rr_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [UART_BYTE_W-1:0] data_q, data_d;
    logic [N_REQ-1:0]       gnt_q, gnt_d;
    logic                   wr_q, wr_d;

    logic [N_REQ-1:0]       pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_vld;
    logic [UART_BYTE_W-1:0] req_bytes [N_REQ];

`ifdef UART_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]       to_cnt_q, to_cnt_d;
    logic                   err_q, err_d;
`endif

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req (bus.req),
        .ptr (rr_q),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .vld (pick_vld)
    );

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_bytes[i] = bus.req_data[UART_BYTE_W*i +: UART_BYTE_W];
        end
    end

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rr_d     = rr_q;
        owner_d  = owner_q;
        data_d   = data_q;
        gnt_d    = '0;
        wr_d     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                wr_cnt_d = '0;
                if (pick_vld && !bus.tx_busy) begin
                    gnt_d   = pick_gnt;
                    data_d  = req_bytes[pick_idx];
                    owner_d = pick_idx;
                    rr_d    = pick_idx;
                    state_d = ST_WRITE;
                end
            end
            // First WRITE cycle only launches the strobe, so tx_wr rises one
            // clock after gnt and is then high for exactly WR_CYCLES clocks.
            ST_WRITE: begin
                if (wr_cnt_q == CNT_W'(WR_CYCLES)) begin
                    wr_cnt_d = '0;
                    state_d  = ST_RELEASE;
                end else begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    wr_d     = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (bus.tx_busy) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!bus.tx_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef UART_ARB_TIMEOUT_EN
        // Timeout restarts on every state change, so RELEASE and DRAIN are
        // each allowed TO_CYCLES clocks on their own.
        to_cnt_d = '0;
        err_d    = err_q;
        if ((state_q == ST_RELEASE || state_q == ST_DRAIN) && state_d == state_q) begin
            if (to_cnt_q == CNT_W'(TO_CYCLES - 1)) begin
                state_d = ST_IDLE;
                err_d   = 1'b1;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            wr_cnt_q <= '0;
            rr_q     <= IW'(N_REQ - 1);
            owner_q  <= '0;
            data_q   <= '0;
            gnt_q    <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_cnt_q <= wr_cnt_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            data_q   <= data_d;
            gnt_q    <= gnt_d;
            wr_q     <= wr_d;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_q    <= err_d;
        end
    end
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign bus.gnt     = gnt_q;
    assign bus.tx_data = data_q;
    assign bus.tx_wr   = wr_q;
    assign bus.tx_ce   = wr_q;
    assign owner       = owner_q;
    assign active      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench for uart_tx_arbiter (N_REQ=4,
// WR_CYCLES=24, TO_CYCLES=64). A transmitter model raises tx_busy 30 clocks
// after tx_wr falls and holds it 120 clocks. Round-robin expectations come
// from a rotate-and-find-lowest-bit model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N        = 4;
    localparam int WR       = 24;
    localparam int TO       = 64;
    localparam int BUSY_DLY = 30;
    localparam int BUSY_LEN = 120;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] owner;
    logic       active;
    logic       timeout_err;

    int errors = 0;
    int checks = 0;
    int model_last = N - 1;
    bit auto_busy = 1'b0;

    uart_tx_arbiter_if #(.N_REQ(N)) bus ();

    uart_tx_arbiter #(
        .N_REQ     (N),
        .WR_CYCLES (WR),
        .TO_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .owner       (owner),
        .active      (active),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Winner = lowest set bit of the request vector rotated to start just
    // after the previous winner.
    function automatic int model_pick(input logic [3:0] r, input int last);
        logic [7:0] dbl;
        logic [3:0] rot;
        logic [3:0] low;
        int         start;
        int         pos;
        start = (last + 1) % N;
        dbl   = {r, r};
        rot   = dbl[start +: 4];
        low   = rot & (~rot + 4'd1);
        case (low)
            4'b0001: pos = 0;
            4'b0010: pos = 1;
            4'b0100: pos = 2;
            default: pos = 3;
        endcase
        return (start + pos) % N;
    endfunction

    // Transmitter model.
    initial begin : xmit_model
        int   phase;
        int   cnt;
        logic prev_wr;
        phase   = 0;
        cnt     = 0;
        prev_wr = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                phase = 0;
                cnt   = 0;
                if (auto_busy) bus.tx_busy = 1'b0;
            end else if (auto_busy) begin
                case (phase)
                    0: if (prev_wr && !bus.tx_wr) begin
                        phase = 1;
                        cnt   = 0;
                    end
                    1: begin
                        cnt++;
                        if (cnt == BUSY_DLY) begin
                            bus.tx_busy = 1'b1;
                            phase = 2;
                            cnt   = 0;
                        end
                    end
                    default: begin
                        cnt++;
                        if (cnt == BUSY_LEN) begin
                            bus.tx_busy = 1'b0;
                            phase = 0;
                        end
                    end
                endcase
            end
            prev_wr = bus.tx_wr;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b0;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b1;
        model_last = N - 1;
    endtask

    task automatic wait_gnt(input int limit, output bit got);
        got = 1'b0;
        for (int c = 0; c < limit && !got; c++) begin
            @(negedge clk);
            if (bus.gnt != '0) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        bus.req      = 4'b1111;
        bus.req_data = 32'hDEADBEEF;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b expected 0000", bus.gnt); end
        checks++; if (bus.tx_wr !== 1'b0) begin errors++; $display("FAIL reset_tx_wr: got %b expected 0", bus.tx_wr); end
        checks++; if (bus.tx_ce !== 1'b0) begin errors++; $display("FAIL reset_tx_ce: got %b expected 0", bus.tx_ce); end
        checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", bus.tx_data); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active: got %b expected 0", active); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
        bus.req = '0;
        rst     = 1'b1;
    endtask

    task automatic test_single();
        int wr_len;
        int ce_bad;
        bit got;
        bit seen_busy;
        do_reset();
        auto_busy    = 1'b1;
        bus.req_data = 32'h0000_0055;
        bus.req      = 4'b0001;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt_latency: got %b expected 0001", bus.gnt); end
        checks++; if (bus.tx_data !== 8'h55) begin errors++; $display("FAIL single_tx_data: got %h expected 55", bus.tx_data); end
        checks++; if (bus.tx_wr !== 1'b0) begin errors++; $display("FAIL single_wr_not_with_gnt: got %b expected 0", bus.tx_wr); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL single_active: got %b expected 1", active); end
        model_last = 0;
        bus.req = '0;
        wr_len = 0;
        ce_bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.tx_ce !== bus.tx_wr) ce_bad++;
            if (bus.tx_wr) wr_len++;
            else if (wr_len > 0) break;
        end
        checks++; if (wr_len != WR) begin errors++; $display("FAIL single_strobe_len: got %0d expected %0d", wr_len, WR); end
        checks++; if (ce_bad != 0) begin errors++; $display("FAIL single_ce_tracks_wr: got %0d differing cycles expected 0", ce_bad); end
        checks++; if (bus.tx_data !== 8'h55) begin errors++; $display("FAIL single_data_hold: got %h expected 55", bus.tx_data); end
        // Second requester waits for the whole frame.
        bus.req_data = 32'h0000_6600;
        bus.req      = 4'b0010;
        got       = 1'b0;
        seen_busy = 1'b0;
        for (int c = 0; c < 400 && !got; c++) begin
            @(negedge clk);
            if (bus.tx_busy) seen_busy = 1'b1;
            if (bus.gnt != '0) got = 1'b1;
        end
        checks++; if (!got) begin errors++; $display("FAIL single_next_gnt_timeout: got none expected 0010"); end
        checks++; if (seen_busy !== 1'b1 || bus.tx_busy !== 1'b0) begin errors++; $display("FAIL single_gnt_after_busy: seen_busy=%b tx_busy=%b expected 1,0", seen_busy, bus.tx_busy); end
        checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL single_next_gnt: got %b expected 0010", bus.gnt); end
        checks++; if (bus.tx_data !== 8'h66) begin errors++; $display("FAIL single_next_data: got %h expected 66", bus.tx_data); end
        bus.req = '0;
    endtask

    task automatic test_round_robin();
        bit got;
        int exp;
        do_reset();
        auto_busy    = 1'b1;
        bus.req_data = 32'hA3A2_A1A0;
        bus.req      = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(400, got);
            exp = model_pick(bus.req, model_last);
            checks++;
            if (!got) begin errors++; $display("FAIL rr_gnt_timeout: grant %0d got none expected %b", g, 4'b1 << exp); end
            else if (bus.gnt !== (4'b1 << exp)) begin errors++; $display("FAIL rr_gnt: grant %0d got %b expected %b", g, bus.gnt, 4'b1 << exp); end
            checks++;
            if (bus.tx_data !== 8'(8'hA0 + exp)) begin errors++; $display("FAIL rr_data: grant %0d got %h expected %h", g, bus.tx_data, 8'(8'hA0 + exp)); end
            model_last = exp;
        end
        bus.req = '0;
    endtask

    task automatic test_wrap();
        bit got;
        do_reset();
        auto_busy    = 1'b1;
        bus.req_data = 32'h4433_2211;
        bus.req      = 4'b0100;
        wait_gnt(400, got);
        checks++; if (!got || owner !== 2'd2) begin errors++; $display("FAIL wrap_owner2: got owner %0d expected 2", owner); end
        bus.req = 4'b0011;
        wait_gnt(400, got);
        checks++; if (!got || bus.gnt !== 4'b0001) begin errors++; $display("FAIL wrap_gnt0: got %b expected 0001", bus.gnt); end
        checks++; if (bus.tx_data !== 8'h11) begin errors++; $display("FAIL wrap_data0: got %h expected 11", bus.tx_data); end
        bus.req = 4'b0010;
        wait_gnt(400, got);
        checks++; if (!got || bus.gnt !== 4'b0010) begin errors++; $display("FAIL wrap_gnt1: got %b expected 0010", bus.gnt); end
        bus.req = '0;
    endtask

    task automatic test_reset_mid_write();
        bit got;
        do_reset();
        auto_busy    = 1'b1;
        bus.req_data = 32'h0000_7788;
        bus.req      = 4'b0010;
        wait_gnt(400, got);
        checks++; if (!got || owner !== 2'd1) begin errors++; $display("FAIL abort_pre_owner: got %0d expected 1", owner); end
        bus.req = 4'b0011;
        for (int c = 0; c < 9; c++) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.tx_wr !== 1'b0 || bus.tx_ce !== 1'b0) begin errors++; $display("FAIL abort_strobe: got wr=%b ce=%b expected 0,0", bus.tx_wr, bus.tx_ce); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL abort_idle: got active=%b expected 0", active); end
        checks++; if (owner !== 2'd0) begin errors++; $display("FAIL abort_owner: got %0d expected 0", owner); end
        rst        = 1'b1;
        model_last = N - 1;
        wait_gnt(400, got);
        checks++; if (!got || bus.gnt !== 4'b0001) begin errors++; $display("FAIL abort_next_gnt: got %b expected 0001", bus.gnt); end
        bus.req = '0;
    endtask

    task automatic test_random();
        bit         got;
        int         exp;
        logic [7:0] exp_byte;
        do_reset();
        auto_busy    = 1'b1;
        bus.req_data = $urandom;
        bus.req      = 4'($urandom_range(1, 15));
        for (int g = 0; g < 8; g++) begin
            wait_gnt(400, got);
            exp      = model_pick(bus.req, model_last);
            exp_byte = bus.req_data[8*exp +: 8];
            checks++;
            if (!got) begin errors++; $display("FAIL rand_gnt_timeout: grant %0d got none expected %b", g, 4'b1 << exp); end
            else if (bus.gnt !== (4'b1 << exp)) begin errors++; $display("FAIL rand_gnt: grant %0d req %b got %b expected %b", g, bus.req, bus.gnt, 4'b1 << exp); end
            checks++;
            if (bus.tx_data !== exp_byte) begin errors++; $display("FAIL rand_data: grant %0d got %h expected %h", g, bus.tx_data, exp_byte); end
            model_last   = exp;
            bus.req_data = $urandom;
            bus.req      = 4'($urandom_range(1, 15));
        end
        bus.req = '0;
    endtask

    task automatic test_busy_hold();
        int early;
        do_reset();
        auto_busy   = 1'b0;
        bus.tx_busy = 1'b1;
        bus.req_data = 32'h0000_00C3;
        bus.req     = 4'b0001;
        early = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.gnt != '0 || active) early++;
        end
        checks++; if (early != 0) begin errors++; $display("FAIL busy_no_gnt: got %0d active/grant cycles expected 0", early); end
        bus.tx_busy = 1'b0;
        @(negedge clk);
        checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL busy_release_gnt: got %b expected 0001", bus.gnt); end
        checks++; if (bus.tx_data !== 8'hC3) begin errors++; $display("FAIL busy_release_data: got %h expected c3", bus.tx_data); end
        bus.req = '0;
    endtask

    task automatic test_timeout();
        bit got;
        bit seen_wr;
        int rel_cycles;
        do_reset();
        auto_busy    = 1'b0;
        bus.tx_busy  = 1'b0;
        bus.req_data = 32'h0000_0042;
        bus.req      = 4'b0001;
        wait_gnt(10, got);
        checks++; if (!got) begin errors++; $display("FAIL timeout_gnt: got none expected 0001"); end
        bus.req = '0;
        seen_wr = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (bus.tx_wr) seen_wr = 1'b1;
            else if (seen_wr) break;
        end
        rel_cycles = active ? 1 : 0;
        for (int c = 0; c < 200 && active; c++) begin
            @(negedge clk);
            if (active) rel_cycles++;
        end
`ifdef UART_ARB_TIMEOUT_EN
        checks++; if (rel_cycles != TO) begin errors++; $display("FAIL timeout_len: got %0d release cycles expected %0d", rel_cycles, TO); end
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b expected 1", timeout_err); end
        repeat (5) @(negedge clk);
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL timeout_sticky: got %b expected 1", timeout_err); end
`else
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL no_timeout_stays: got active=%b expected 1", active); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL no_timeout_flag: got %b expected 0", timeout_err); end
`endif
        do_reset();
        @(negedge clk);
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL timeout_clear_on_reset: got %b expected 0", timeout_err); end
    endtask

    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.tx_busy  = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_wrap();
        test_reset_mid_write();
        test_random();
        test_busy_hold();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
